// File: rtl/nbit_demux_reg_if.sv
// nbit_demux_reg_if: write-side bus of the registered 1-to-4 demultiplexer
interface nbit_demux_reg_if #(parameter int N = 4);
  logic [N-1:0] din;
  logic [1:0] s;
  logic mode;
  logic we;
  logic [3:0] ack;
  logic [N-1:0] y0, y1, y2, y3;
  logic [3:0] v;
  logic [1:0] ptr;
  logic full;
  logic ovf;
  modport master (
    output din, s, mode, we, ack,
    input y0, y1, y2, y3, v, ptr, full, ovf
  );
  modport slave (
    input din, s, mode, we, ack,
    output y0, y1, y2, y3, v, ptr, full, ovf
  );
endinterface

// File: rtl/nbit_demux_reg.sv
// nbit_demux_reg: routes one N-bit word into one of four valid-flagged holding registers
module nbit_demux_reg #(parameter int N = 4) (
  input logic clk,
  input logic rst,
  nbit_demux_reg_if.slave bus
);
  logic [N-1:0] y [4];
  logic [3:0] v;
  logic [1:0] ptr;
  logic ovf;
  logic [1:0] t;
  logic busy, acc, rej;
  // target channel and accept/reject decision; a same-cycle ack frees a full channel
  always_comb begin
    t = bus.mode ? ptr : bus.s;
    busy = v[t] & ~bus.ack[t];
    acc = bus.we & ~busy;
    rej = bus.we & busy;
  end
  // channel registers, valid flags, round-robin pointer and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) y[k] <= '0;
      v <= '0;
      ptr <= '0;
      ovf <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) if (acc && t == 2'(k)) y[k] <= bus.din;
      v <= (v & ~bus.ack) | (acc ? 4'b0001 << t : 4'b0000);
      ptr <= ptr + {1'b0, acc & bus.mode};
      ovf <= ovf | rej;
    end
  end
  assign bus.y0 = y[0];
  assign bus.y1 = y[1];
  assign bus.y2 = y[2];
  assign bus.y3 = y[3];
  assign bus.v = v;
  assign bus.ptr = ptr;
  assign bus.full = &v;
  assign bus.ovf = ovf;
endmodule

// File: tb/tb_nbit_demux_reg.sv
// tb_nbit_demux_reg: directed checks of the registered 1-to-4 demultiplexer
module tb_nbit_demux_reg;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] s3;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  nbit_demux_reg_if #(.N(N)) bus ();
  nbit_demux_reg #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic m, input logic [1:0] sel, input logic [N-1:0] d, input logic [3:0] a);
    bus.mode = m;
    bus.s = sel;
    bus.din = d;
    bus.ack = a;
    bus.we = 1'b1;
    step();
    bus.we = 1'b0;
    bus.ack = 4'b0000;
  endtask
  task automatic ack_only(input logic [3:0] a);
    bus.ack = a;
    bus.we = 1'b0;
    step();
    bus.ack = 4'b0000;
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic fill_addr();
    for (int i = 0; i < 4; i++) wr(1'b0, 2'(i), N'(i + 1), 4'b0000);
  endtask
  initial begin
    bus.din = '0;
    bus.s = '0;
    bus.mode = 1'b0;
    bus.we = 1'b0;
    bus.ack = '0;
    s3 = '0;
    step();
    chk("rst_v", bus.v, 4'b0000);
    chk("rst_y0", bus.y0, 0);
    chk("rst_full", bus.full, 0);
    rst = 1'b0;
    fill_addr();
    chk("addr_y0", bus.y0, 1);
    chk("addr_y1", bus.y1, 2);
    chk("addr_y2", bus.y2, 3);
    chk("addr_y3", bus.y3, 4);
    chk("addr_v", bus.v, 4'b1111);
    chk("addr_full", bus.full, 1);
    chk("addr_ptr", bus.ptr, 0);
    chk("addr_ovf", bus.ovf, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_y0", bus.y0, 0);
    chk("async_y3", bus.y3, 0);
    chk("async_v", bus.v, 4'b0000);
    chk("async_full", bus.full, 0);
    chk("async_ptr", bus.ptr, 0);
    bus.we = 1'b1;
    bus.din = 8'hEE;
    step();
    chk("rst_ignores_we", bus.v, 4'b0000);
    bus.we = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) wr(1'b1, 2'b00, N'(i + 5), 4'b0000);
    chk("rr_y0", bus.y0, 5);
    chk("rr_y1", bus.y1, 6);
    chk("rr_y2", bus.y2, 7);
    chk("rr_y3", bus.y3, 8);
    chk("rr_ptr_wrap", bus.ptr, 0);
    chk("rr_ovf_before", bus.ovf, 0);
    wr(1'b1, 2'b00, 8'd9, 4'b0000);
    chk("rej_y0", bus.y0, 5);
    chk("rej_ptr", bus.ptr, 0);
    chk("rej_ovf", bus.ovf, 1);
    chk("rej_v", bus.v, 4'b1111);
    ack_only(4'b0100);
    chk("ovf_sticky", bus.ovf, 1);
    chk("ack_v", bus.v, 4'b1011);
    chk("ack_y2_kept", bus.y2, 7);
    do_reset();
    fill_addr();
    wr(1'b0, 2'b00, 8'h0A, 4'b0001);
    chk("ackwr_y0", bus.y0, 8'h0A);
    chk("ackwr_v", bus.v, 4'b1111);
    chk("ackwr_ovf", bus.ovf, 0);
    ack_only(4'b0001);
    chk("ack0_v", bus.v, 4'b1110);
    chk("ack0_full", bus.full, 0);
    chk("ack0_y0", bus.y0, 8'h0A);
    ack_only(4'b1011);
    chk("multi_ack_v", bus.v, 4'b0100);
    do_reset();
    wr(1'b1, 2'b00, 8'd11, 4'b0000);
    wr(1'b1, 2'b00, 8'd12, 4'b0000);
    chk("ms_ptr2", bus.ptr, 2);
    chk("ms_y1", bus.y1, 12);
    wr(1'b0, 2'b11, 8'd13, 4'b0000);
    chk("ms_ptr_hold", bus.ptr, 2);
    chk("ms_y3", bus.y3, 13);
    wr(1'b1, 2'b00, 8'd14, 4'b0000);
    chk("ms_y2", bus.y2, 14);
    chk("ms_ptr3", bus.ptr, 3);
    chk("ms_v", bus.v, 4'b1111);
    do_reset();
    s3 = 3'b100;
    wr(1'b0, s3[1:0], 8'h55, 4'b0000);
    chk("oor_y0", bus.y0, 8'h55);
    chk("oor_y1", bus.y1, 0);
    chk("oor_y2", bus.y2, 0);
    chk("oor_y3", bus.y3, 0);
    chk("oor_v", bus.v, 4'b0001);
    ack_only(4'b0010);
    chk("ack_clear_noop", bus.v, 4'b0001);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
